xnor_lfsr_gen: RTL and testbench

- Bit-serial-feedback pseudo-random operand generator for the ALU demo.
- Generates bursts of N-bit words from an XNOR-feedback Fibonacci LFSR and presents them on a valid/ready stream.
- Feeds the ALU operand registers and the self-check path; it is the generating end of the XNOR equality-compare path.
- Sequence state persists across bursts; a seed can be loaded while idle.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/xnor_lfsr_core.sv | 44 ++++
 rtl/xnor_lfsr_gen.sv | 133 +++++++++++++
 tb/tb_xnor_lfsr_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU demo operand generator.
//   gen_state_t : generator FSM states
//   LFSR8_TAPS  : maximal-length XNOR tap mask for an 8-bit LFSR (bits 7,5,4,3)
//   is_lockup   : detects the XNOR-LFSR lock-up value (all ones) in the low
//                 'width' bits of a value, so seeds can be substituted with 0.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    localparam logic [7:0] LFSR8_TAPS = 8'hB8;

    // True when the low 'width' bits of val are all ones (valid for width <= 63).
    function automatic logic is_lockup(input logic [63:0] val, input int unsigned width);
        logic [63:0] mask_s;
        mask_s = (64'd1 << width) - 64'd1;
        is_lockup = ((val & mask_s) == mask_s);
    endfunction

endpackage

// File: rtl/xnor_lfsr_core.sv
// XNOR-feedback Fibonacci LFSR register.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset, clears the register to 0
//   load     : load load_val (has priority over step)
//   load_val : value to load (caller guarantees it is not the lock-up value)
//   step     : advance one position: q <= {q[N-2:0], ~^(q & TAPS)}
//   q        : current register contents
module xnor_lfsr_core
    import alu_pkg::*;
#(
    parameter int             N    = 8,
    parameter logic [N-1:0]   TAPS = N'(LFSR8_TAPS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         step,
    output logic [N-1:0] q
);

    logic [N-1:0] lfsr_r;
    logic         fb_s;

    // XNOR feedback keeps all-zero legal; all-ones is the stuck state instead.
    assign fb_s = ~^(lfsr_r & TAPS);

    // LFSR register: reset, load, shift, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= {N{1'b0}};
        end else if (load) begin
            lfsr_r <= load_val;
        end else if (step) begin
            lfsr_r <= {lfsr_r[N-2:0], fb_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign q = lfsr_r;

endmodule

// File: rtl/xnor_lfsr_gen.sv
// Burst generator of pseudo-random N-bit words on a valid/ready stream.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   start, count      : begin a burst of 'count' words (IDLE only)
//   seed_load, seed_in: load LFSR seed (IDLE only, priority over start);
//                       an all-ones seed is loaded as 0
//   out_data/out_valid/out_ready : output stream
//   busy              : high in RUN and DONE
//   done              : one-cycle pulse after the last word is accepted
module xnor_lfsr_gen
    import alu_pkg::*;
#(
    parameter int           N    = 8,
    parameter logic [N-1:0] TAPS = N'(LFSR8_TAPS),
    parameter int           CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] count,
    input  logic          seed_load,
    input  logic [N-1:0]  seed_in,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    gen_state_t    state_r;
    logic [CW-1:0] remaining_r;
    logic          out_valid_r;
    logic          busy_r;
    logic          done_r;

    logic          load_s;
    logic [N-1:0]  load_val_s;
    logic          step_s;
    logic          accept_s;

    // Seeds are honoured only while idle; the all-ones lock-up seed becomes 0.
    assign load_s     = (state_r == IDLE) && seed_load;
    assign load_val_s = is_lockup({{(64-N){1'b0}}, seed_in}, N) ? {N{1'b0}} : seed_in;

    // A word is consumed only on a real handshake, so the LFSR holds under backpressure.
    assign accept_s = (state_r == RUN) && out_valid_r && out_ready;
    assign step_s   = accept_s;

    xnor_lfsr_core #(
        .N    (N),
        .TAPS (TAPS)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .step     (step_s),
        .q        (out_data)
    );

    // Burst FSM with registered valid/busy/done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            remaining_r <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (seed_load) begin
                        // Seed load wins; a simultaneous start is dropped.
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else if (start && (count != {CW{1'b0}})) begin
                        state_r     <= RUN;
                        remaining_r <= count;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else if (start) begin
                        // Empty burst: go straight to the done pulse.
                        state_r     <= DONE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        // remaining is nonzero in RUN, so this never wraps.
                        remaining_r <= remaining_r - {{(CW-1){1'b0}}, 1'b1};
                        if (remaining_r == {{(CW-1){1'b0}}, 1'b1}) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            state_r     <= RUN;
                            out_valid_r <= 1'b1;
                        end
                    end else begin
                        state_r     <= RUN;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    remaining_r <= {CW{1'b0}};
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_xnor_lfsr_gen.sv
// Directed testbench for xnor_lfsr_gen (N=8, TAPS=8'hB8, CW=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_xnor_lfsr_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] count;
    logic       seed_load;
    logic [7:0] seed_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    xnor_lfsr_gen #(.N(8), .TAPS(8'hB8), .CW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference step of the XNOR LFSR with taps 7,5,4,3.
    function automatic logic [7:0] ref_next(input logic [7:0] v);
        ref_next = {v[6:0], ~(v[7] ^ v[5] ^ v[4] ^ v[3])};
    endfunction

    task automatic do_seed(input logic [7:0] s);
        seed_load = 1'b1; seed_in = s; tick(); seed_load = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] c);
        start = 1'b1; count = c; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        checks++;
        if (out_data !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got data=%h valid=%b busy=%b done=%b expected 00 0 0 0",
                     out_data, out_valid, busy, done);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_w [7];
        exp_w = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        out_ready = 1'b1;
        do_start(8'd7);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL burst_word%0d: got valid=%b data=%h busy=%b expected 1 %h 1",
                         i, out_valid, out_data, busy, exp_w[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL burst_done: got done=%b valid=%b busy=%b expected 1 0 1", done, out_valid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_seed();
        do_seed(8'h0F);
        do_start(8'd2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h0F) begin
            errors++;
            $display("FAIL seed_word0: got valid=%b data=%h expected 1 0f", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h1E) begin
            errors++;
            $display("FAIL seed_word1: got valid=%b data=%h expected 1 1e", out_valid, out_data);
        end
        tick();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL seed_done: got done=%b valid=%b expected 1 0", done, out_valid);
        end
        tick();
    endtask

    task automatic test_lockup();
        do_seed(8'hFF);
        do_start(8'd1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL lockup_subst: got valid=%b data=%h expected 1 00", out_valid, out_data);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL lockup_done: got done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_seed(8'h00);
        out_ready = 1'b1;
        do_start(8'd3);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL bp_word0: got valid=%b data=%h expected 1 00", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h01) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h expected 1 01", i, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01) begin
            errors++;
            $display("FAIL bp_word1: got valid=%b data=%h expected 1 01", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h03) begin
            errors++;
            $display("FAIL bp_word2: got valid=%b data=%h expected 1 03", out_valid, out_data);
        end
        tick();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: got done=%b valid=%b expected 1 0", done, out_valid);
        end
        tick();
    endtask

    task automatic test_count_zero();
        do_start(8'd0);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got valid=%b done=%b busy=%b expected 0 1 1", out_valid, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got done=%b busy=%b valid=%b expected 0 0 0", done, busy, out_valid);
        end
    endtask

    task automatic test_start_during_run();
        logic [7:0] exp_w [3];
        exp_w = '{8'h00, 8'h01, 8'h03};
        do_seed(8'h00);
        out_ready = 1'b0;
        do_start(8'd3);
        do_start(8'd9);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL run_start_hold: got valid=%b data=%h expected 1 00", out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
                errors++;
                $display("FAIL run_start_word%0d: got valid=%b data=%h expected 1 %h",
                         i, out_valid, out_data, exp_w[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_start_done: got done=%b valid=%b expected 1 0", done, out_valid);
        end
        tick();
    endtask

    task automatic test_seed_start_same();
        seed_load = 1'b1; seed_in = 8'h55; start = 1'b1; count = 8'd4;
        tick();
        seed_load = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h55) begin
            errors++;
            $display("FAIL seed_start_same: got busy=%b valid=%b data=%h expected 0 0 55",
                     busy, out_valid, out_data);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL seed_start_noburst: got busy=%b done=%b expected 0 0", busy, done);
        end
        do_start(8'd1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55) begin
            errors++;
            $display("FAIL seed_start_word: got valid=%b data=%h expected 1 55", out_valid, out_data);
        end
        tick();
        tick();
    endtask

    task automatic test_period();
        logic [255:0] seen;
        logic [7:0]   m;
        seen = '0;
        m = 8'h00;
        do_seed(8'h00);
        out_ready = 1'b1;
        do_start(8'd255);
        for (int i = 0; i < 255; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== m || out_data === 8'hFF || seen[out_data] === 1'b1) begin
                errors++;
                $display("FAIL period_word%0d: got valid=%b data=%h expected 1 %h (distinct, not ff)",
                         i, out_valid, out_data, m);
            end
            if (out_data !== 8'hFF) seen[out_data] = 1'b1;
            m = ref_next(m);
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL period_done: got done=%b expected 1", done);
        end
        tick();
        do_start(8'd1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL period_wrap: got valid=%b data=%h expected 1 00", out_valid, out_data);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_seed(8'h3D);
        out_ready = 1'b1;
        do_start(8'd5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got valid=%b busy=%b data=%h done=%b expected 0 0 00 0",
                     out_valid, busy, out_data, done);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_nodone%0d: got done=%b valid=%b expected 0 0", i, done, out_valid);
            end
        end
        do_start(8'd2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_restart0: got valid=%b data=%h expected 1 00", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01) begin
            errors++;
            $display("FAIL midreset_restart1: got valid=%b data=%h expected 1 01", out_valid, out_data);
        end
        tick();
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        count     = 8'd0;
        seed_load = 1'b0;
        seed_in   = 8'h00;
        out_ready = 1'b1;
        tick();
        test_reset();
        test_burst();
        test_seed();
        test_lockup();
        test_backpressure();
        test_count_zero();
        test_start_during_run();
        test_seed_start_same();
        test_period();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
